// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle req/ack clock-domain crossing blocks
// (launching side and the paired capture side).
package cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_tx_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Counter width able to hold 0..cyc; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int cyc);
    return (cyc > 0) ? $clog2(cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on rst.
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_bus_tx.sv
// Launching side of a two-phase toggle req/ack bus crossing: holds the word
// on tx_data, toggles tx_req, and waits for the synchronized ack toggle.
module cdc_bus_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DATA_WDTH-1:0] s_data,
  output logic                 s_ready,
  output logic [DATA_WDTH-1:0] tx_data,
  output logic                 tx_req,
  input  logic                 tx_ack,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W:0] TO_LAST = (CNT_W + 1)'(TIMEOUT_CYC);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("cdc_bus_tx: SYNC_STAGES out of legal range");
  end

  cdc_tx_state_t    state, state_nxt;
  logic             ack_s;
  logic             ack_match;
  logic             hs;
  logic             to_hit;
  logic [CNT_W-1:0] to_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (tx_ack),
    .q  (ack_s)
  );

  assign ack_match = (ack_s == tx_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (s_valid)   state_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_match) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == IDLE);
    busy    = (state == WAIT_ACK);
    hs      = s_ready && s_valid;
  end

  // Word and request change together so the destination never sees a new req
  // with stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= '0;
      tx_req  <= 1'b0;
    end else if (hs) begin
      tx_data <= s_data;
      tx_req  <= ~tx_req;
    end
  end

  // An ack arriving on the timeout edge wins: to_hit is gated by !ack_match.
  assign to_hit = (TIMEOUT_CYC != 0) && busy && !ack_match &&
                  (({1'b0, to_cnt} + 1'b1) == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (hs) begin
        to_cnt <= '0;
      end else if (busy && !ack_match) begin
        to_cnt <= sat_inc(to_cnt);
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_bus_tx.sv
// Randomized and directed bench for cdc_bus_tx against a cycle-level
// behavioural model of the handshake rules.
module tb_cdc_bus_tx;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TO   = 16;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [DW-1:0] tx_data;
  logic          tx_req;
  logic          tx_ack;
  logic          busy;
  logic          timeout_err;

  int errs   = 0;
  int checks = 0;

  cdc_bus_tx #(
    .DATA_WDTH  (DW),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .tx_ack     (tx_ack),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: ack level seen SYNC edges late, cycle count since launch.
  logic          m_busy, m_req, m_err;
  logic [DW-1:0] m_data;
  int            m_wait;
  logic          m_ack_log [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_req  <= 1'b0;
      m_err  <= 1'b0;
      m_data <= '0;
      m_wait <= 0;
      m_ack_log = {};
      for (int i = 0; i < SYNC; i++) m_ack_log.push_back(1'b0);
    end else begin
      if (!m_busy) begin
        if (s_valid) begin
          m_data <= s_data;
          m_req  <= ~m_req;
          m_busy <= 1'b1;
          m_wait <= 0;
        end
      end else if (m_ack_log[0] == m_req) begin
        m_busy <= 1'b0;
      end else begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 == TO) m_err <= 1'b1;
      end
      void'(m_ack_log.pop_front());
      m_ack_log.push_back(tx_ack);
    end
  end

  wire [DW+3:0] dut_vec = {s_ready, busy, tx_req, timeout_err, tx_data};
  wire [DW+3:0] mdl_vec = {~m_busy, m_busy, m_req, m_err, m_data};

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; tx_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errs++; $display("FAIL reset_values got=%h exp=%h", dut_vec, {1'b1, 3'b000, 8'h00});
    end
    checks++;
    if (dut_vec !== mdl_vec) begin
      errs++; $display("FAIL reset_model got=%h exp=%h", dut_vec, mdl_vec);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    s_valid = 1'b1; s_data = 8'hA5;
    @(negedge clk);
    checks++;
    if ({tx_req, tx_data, s_ready} !== {1'b1, 8'hA5, 1'b0}) begin
      errs++; $display("FAIL single_launch got req=%b data=%h rdy=%b exp req=1 data=a5 rdy=0", tx_req, tx_data, s_ready);
    end
    s_valid = 1'b0; s_data = 8'($urandom);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errs++; $display("FAIL single_wait got=%h exp=%h", dut_vec, mdl_vec);
      end
    end
    tx_ack = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errs++; $display("FAIL single_ack got=%h exp=%h", dut_vec, mdl_vec);
      end
    end while (s_ready !== 1'b1 && n < 20);
    checks++;
    if (n !== SYNC + 1) begin
      errs++; $display("FAIL single_ready_latency got=%0d exp=%0d", n, SYNC + 1);
    end
  endtask

  task automatic test_spurious();
    logic [DW+3:0] snap;
    logic          nreq;
    int            n;
    snap = dut_vec;
    tx_ack = ~tx_ack;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== snap || dut_vec !== mdl_vec) begin
        errs++; $display("FAIL spurious_hold got=%h exp=%h", dut_vec, snap);
      end
    end
    tx_ack = ~tx_ack;
    repeat (3) @(negedge clk);
    nreq = ~m_req;
    s_valid = 1'b1; s_data = 8'($urandom);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (tx_req !== nreq || busy !== 1'b1) begin
      errs++; $display("FAIL spurious_launch got req=%b busy=%b exp req=%b busy=1", tx_req, busy, nreq);
    end
    repeat (2) @(negedge clk);
    tx_ack = nreq;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errs++; $display("FAIL spurious_done got=%h exp=%h", dut_vec, mdl_vec);
      end
    end while (s_ready !== 1'b1 && n < 20);
    checks++;
    if (s_ready !== 1'b1) begin
      errs++; $display("FAIL spurious_complete got rdy=%b exp 1", s_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [DW-1:0] seen [$];
    logic [DW-1:0] hold;
    logic          prev_req;
    int            toggles, ack_dly;
    toggles = 0; ack_dly = 0; prev_req = m_req; hold = '0;
    s_valid = 1'b1; s_data = words[0];
    for (int c = 0; c < 200 && !(toggles == 4 && s_ready === 1'b1 && ack_dly == 0); c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errs++; $display("FAIL b2b_model got=%h exp=%h", dut_vec, mdl_vec);
      end
      if (ack_dly > 0) begin
        ack_dly--;
        if (ack_dly == 0) tx_ack = prev_req;
      end
      if (tx_req !== prev_req) begin
        prev_req = tx_req; hold = tx_data; seen.push_back(tx_data);
        toggles++; ack_dly = 4;
      end else if (busy === 1'b1) begin
        checks++;
        if (tx_data !== hold) begin
          errs++; $display("FAIL b2b_stable got=%h exp=%h", tx_data, hold);
        end
      end
      s_valid = (toggles < 4);
      s_data  = (busy === 1'b1) ? 8'($urandom) : words[(toggles < 4) ? toggles : 3];
    end
    s_valid = 1'b0;
    checks++;
    if (toggles !== 4 || seen.size() !== 4) begin
      errs++; $display("FAIL b2b_count got toggles=%0d words=%0d exp 4", toggles, seen.size());
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== words[i]) begin
        errs++; $display("FAIL b2b_word%0d got=%h exp=%h", i, seen[i], words[i]);
      end
    end
  endtask

  task automatic test_random();
    logic prev_req, ack_tgt;
    int   ack_dly, toggles;
    prev_req = m_req; ack_tgt = tx_ack; ack_dly = 0; toggles = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errs++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec);
      end
      if (ack_dly > 0) begin
        ack_dly--;
        if (ack_dly == 0) tx_ack = ack_tgt;
      end
      if (tx_req !== prev_req) begin
        prev_req = tx_req; ack_tgt = tx_req; toggles++;
        ack_dly = $urandom_range(8, 1);
      end
      s_valid = (c < 380) ? 1'($urandom) : 1'b0;
      s_data  = 8'($urandom);
    end
    checks++;
    if (toggles < 10 || s_ready !== 1'b1) begin
      errs++; $display("FAIL random_progress got toggles=%0d rdy=%b exp >=10 and 1", toggles, s_ready);
    end
  endtask

  task automatic test_timeout();
    int n;
    s_valid = 1'b1; s_data = 8'($urandom);
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errs++; $display("FAIL timeout_model got=%h exp=%h", dut_vec, mdl_vec);
      end
    end while (timeout_err !== 1'b1 && n < 40);
    checks++;
    if (n !== TO || busy !== 1'b1) begin
      errs++; $display("FAIL timeout_edge got cycles=%0d busy=%b exp %0d busy=1", n, busy, TO);
    end
    tx_ack = m_req;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_ready !== 1'b1 && n < 20);
    checks++;
    if (s_ready !== 1'b1 || timeout_err !== 1'b1) begin
      errs++; $display("FAIL timeout_sticky got rdy=%b err=%b exp 1 1", s_ready, timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1; tx_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h5C;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_req !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL rstmid_pre got req=%b busy=%b exp 1 1", tx_req, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_req, tx_data, busy, timeout_err} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      errs++; $display("FAIL rstmid_clear got req=%b data=%h busy=%b err=%b exp 0 00 0 0", tx_req, tx_data, busy, timeout_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || dut_vec !== mdl_vec) begin
      errs++; $display("FAIL rstmid_ready got=%h exp=%h", dut_vec, mdl_vec);
    end
    s_valid = 1'b1; s_data = 8'h3E;
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (tx_req !== 1'b1 || tx_data !== 8'h3E) begin
      errs++; $display("FAIL rstmid_next got req=%b data=%h exp 1 3e", tx_req, tx_data);
    end
    tx_ack = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_ready !== 1'b1 && n < 20);
    checks++;
    if (dut_vec !== mdl_vec || s_ready !== 1'b1) begin
      errs++; $display("FAIL rstmid_done got=%h exp=%h", dut_vec, mdl_vec);
    end
  endtask

  task automatic test_ack_at_timeout();
    s_valid = 1'b1; s_data = 8'($urandom);
    @(negedge clk);
    s_valid = 1'b0;
    // Ack first sampled SYNC edges before the timeout edge lands exactly on it.
    repeat (TO - SYNC - 1) @(negedge clk);
    tx_ack = m_req;
    repeat (SYNC) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0) begin
        errs++; $display("FAIL acktie_wait got busy=%b err=%b exp 1 0", busy, timeout_err);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1 || timeout_err !== 1'b0) begin
      errs++; $display("FAIL acktie_idle got busy=%b rdy=%b err=%b exp 0 1 0", busy, s_ready, timeout_err);
    end
    checks++;
    if (dut_vec !== mdl_vec) begin
      errs++; $display("FAIL acktie_model got=%h exp=%h", dut_vec, mdl_vec);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_spurious();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    test_ack_at_timeout();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cdc_bus_tx.md
# cdc_bus_tx

Source-domain (launching) side of a two-phase toggle req/ack bus handshake used to move multi-bit words across a clock-domain boundary. It accepts a word through a valid/ready port, holds it stable on `tx_data`, and toggles `tx_req`. It then waits for the destination's toggled `tx_ack`, which arrives asynchronously and is synchronized inside the block. The block pairs with a destination-side capture block, which samples `tx_data` after synchronizing `tx_req` and returns `tx_ack`.

## Interface
Parameters:
- `DATA_WDTH`, default 8: width of the transported word.
- `SYNC_STAGES`, default 2: flop stages on the `tx_ack` synchronizer; legal range 2..4.
- `TIMEOUT_CYC`, default 1024: number of cycles in WAIT_ACK before `timeout_err` is raised; 0 disables the timeout.

Ports (one clock; reset is asynchronous, active-high):
- `clk`  in  1  source-domain clock.
- `rst`  in  1  asynchronous active-high reset.
- `s_valid`  in  1  upstream word valid.
- `s_data`  in  `DATA_WDTH`  upstream word.
- `s_ready`  out  1  block can accept a word.
- `tx_data`  out  `DATA_WDTH`  registered word; stable for the whole transfer.
- `tx_req`  out  1  request toggle, registered.
- `tx_ack`  in  1  acknowledge toggle from the destination domain; asynchronous.
- `busy`  out  1  a transfer is outstanding.
- `timeout_err`  out  1  sticky flag: ack not seen within `TIMEOUT_CYC` cycles.

## Operation
- Two-state FSM, IDLE and WAIT_ACK. Reset state is IDLE.
- `s_ready` = (state == IDLE). `busy` = (state == WAIT_ACK).
- IDLE, when `s_valid` is high (a handshake):
  - load `s_data` into `tx_data`;
  - invert `tx_req`;
  - go to WAIT_ACK.
- IDLE, when `s_valid` is low: hold all outputs.
- `tx_ack` passes through `SYNC_STAGES` flops to produce `ack_s`. Nothing else samples raw `tx_ack`.
- WAIT_ACK:
  - stay while `ack_s != tx_req`;
  - when `ack_s == tx_req`, go to IDLE;
  - `tx_data` and `tx_req` are frozen.
- `s_data` and `s_valid` are ignored while `s_ready` is low.
- Timeout counter:
  - clears on entry to WAIT_ACK and increments every WAIT_ACK cycle, saturating;
  - width is $clog2(`TIMEOUT_CYC`+1);
  - reaching `TIMEOUT_CYC` sets `timeout_err`;
  - `timeout_err` clears only on `rst`;
  - the FSM keeps waiting after a timeout; there is no retry and no abort.
- Reset values:
  - `tx_req`=0, `tx_data`=0, `busy`=0, `timeout_err`=0;
  - all synchronizer flops = 0;
  - `s_ready`=1 once the state is IDLE.
- Reset mid-transfer: the state returns to IDLE and `tx_req` returns to 0. The destination side must be reset in the same event so that both toggles restart at 0. This is a system requirement and is not checked by the block.
- Spurious ack: an `ack_s` change while in IDLE has no effect.

## Timing
- Handshake at edge 0 → `tx_req` toggled and `tx_data` valid from edge 0. `s_ready` low from edge 0.
- Setup guarantee: `tx_data` changes in the same cycle as `tx_req` and stays stable until the next handshake. The destination samples `tx_data` only after its synchronized req has changed, which is at least 2 of its own clock cycles later.
- The new `tx_ack` level is first sampled at edge A:
  - `ack_s` reflects it after edge A+`SYNC_STAGES`-1;
  - the FSM returns to IDLE at edge A+`SYNC_STAGES`;
  - `s_ready` is high in the cycle after that edge.
- Peak throughput: one word per (`SYNC_STAGES`+1 + destination round trip) cycles. There is no back-to-back acceptance.
- `timeout_err` rises at the edge where the counter reaches `TIMEOUT_CYC`. When the ack arrives in the same cycle, the ack wins, the FSM goes to IDLE, and the flag is not set.

## Structure
- Package `cdc_pkg` holds:
  - the `cdc_tx_state_t` enum (IDLE, WAIT_ACK);
  - the legal `SYNC_STAGES` bounds as constants.
  The paired destination block reuses this package.
- Sub-module `cdc_sync_bit`:
  - parameter `SYNC_STAGES`;
  - `clk`, `rst` (asynchronous active-high, clears to 0), `d`, `q`;
  - all stages marked as asynchronous registers for placement.
- The top level holds the FSM, the data register, the req flop and the timeout counter.

## Test plan
- Single transfer, default parameters:
  - stimulus: `s_data`=0xA5 with `s_valid` at cycle 0; `tx_ack` toggled 5 cycles later;
  - response: `tx_req` 0→1 at edge 0, `tx_data`=0xA5, `s_ready` low; `s_ready` high again 3 cycles after the ack sample.
- Back-to-back stream:
  - stimulus: 4 words 0x01..0x04 with `s_valid` held high, driven by a bench responder with a 4-cycle ack delay;
  - response: each word appears exactly once on `tx_data`; `tx_req` toggles 4 times; `tx_data` never changes while `busy`=1.
- Timeout:
  - stimulus: `TIMEOUT_CYC`=16; ack withheld;
  - response: `timeout_err`=1 exactly 16 cycles after the handshake while `busy` stays 1; a later ack returns the FSM to IDLE and `timeout_err` stays 1.
- Ack in the same cycle as timeout:
  - response: state goes to IDLE and `timeout_err` stays 0.
- Reset mid-transfer:
  - stimulus: `rst` asserted while in WAIT_ACK with `tx_req`=1;
  - response: `tx_req`=0, `tx_data`=0, `busy`=0; `s_ready`=1 after release; the next transfer toggles `tx_req` to 1.
- Spurious ack in IDLE:
  - stimulus: toggle `tx_ack` while idle;
  - response: no change on any output; the next transfer still completes on a correct ack.
